// File: rtl/data_sram_resp.sv
// data_sram_resp: single-outstanding data SRAM responder for the MEM stage.
// A request is accepted when req && addr_ok. The memory is read or written
// on that same edge. data_ok pulses for one cycle, a fixed number of cycles
// later, and completes the request.
// Optional feature macro: DATA_SRAM_RAND_DELAY_EN. When it is defined, a
// 16-bit LFSR adds 0..3 extra cycles to each request's delay.
// Handshake: the request is taken on a rising edge where req=1 and addr_ok=1.
// addr_ok is low only in WAIT. data_ok completes the oldest, and only,
// outstanding request. rdata is meaningful only while data_ok=1.
module data_sram_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [4:0]        cnt;
    logic [31:0]       result;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              accept;
    logic [4:0]        delay;
    logic              unused_bits;

    // Only the word-index bits select a location; the remaining bits wrap.
    assign idx         = addr[ADDR_W+1:2];
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    assign addr_ok = (state != WAIT);
    assign accept  = req && addr_ok && resetn;
    assign data_ok = (state == RESP);
    // rdata stays 0 outside the completion cycle and for writes.
    assign rdata   = data_ok ? result : 32'd0;

`ifdef DATA_SRAM_RAND_DELAY_EN
    logic [15:0] lfsr;

    // Free-running LFSR; its low two bits are sampled at acceptance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign delay = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign delay = 5'(LATENCY);
`endif

    // Memory array is never reset. Writes merge only the strobed lanes.
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Response FSM. The down-counter holds the number of WAIT cycles still
    // to run before RESP. A new request may be taken during RESP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        result <= wr ? 32'd0 : mem[idx];
                        if (delay == 5'd1) begin
                            state <= RESP;
                        end else begin
                            cnt   <= delay - 5'd2;
                            state <= WAIT;
                        end
                    end else if (state == RESP) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 5'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed and random checks of data_sram_resp.
// DUT A uses LATENCY=2 and carries all single-request scenarios plus the
// random traffic. DUT B uses LATENCY=1 and carries the back-to-back stream.
module tb_data_sram_resp;

    localparam int AW    = 10;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;
`ifdef DATA_SRAM_RAND_DELAY_EN
    localparam int N_RAND = 200;
`else
    localparam int N_RAND = 60;
`endif

    logic        clk;
    logic        resetn;

    logic        a_req, a_wr;
    logic [1:0]  a_size;
    logic [3:0]  a_wstrb;
    logic [31:0] a_addr, a_wdata;
    logic        a_addr_ok, a_data_ok;
    logic [31:0] a_rdata;

    logic        b_req, b_wr;
    logic [1:0]  b_size;
    logic [3:0]  b_wstrb;
    logic [31:0] b_addr, b_wdata;
    logic        b_addr_ok, b_data_ok;
    logic [31:0] b_rdata;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    data_sram_resp #(.ADDR_W(AW), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .resetn(resetn), .req(a_req), .wr(a_wr), .size(a_size),
        .wstrb(a_wstrb), .addr(a_addr), .wdata(a_wdata),
        .addr_ok(a_addr_ok), .data_ok(a_data_ok), .rdata(a_rdata)
    );

    data_sram_resp #(.ADDR_W(AW), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .resetn(resetn), .req(b_req), .wr(b_wr), .size(b_size),
        .wstrb(b_wstrb), .addr(b_addr), .wdata(b_wdata),
        .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata)
    );

    // Clock and a hard time limit.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 32'd4) % 32'(1 << AW));
    endfunction

    // Reference model: record the expected response and apply any write.
    task automatic model_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        int          wi;
        logic [31:0] cur;
        wi = word_of(a);
        if (w) begin
            exp_q.push_back(32'd0);
            cur = ref_mem[wi];
            for (int i = 0; i < 4; i++) begin
                if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
            end
            ref_mem[wi] = cur;
        end else begin
            exp_q.push_back(ref_mem[wi]);
        end
    endtask

    // Drive one request into DUT A. Call it at a negedge. It returns at the
    // negedge just after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        int guard;
        guard = 0;
        while (a_addr_ok !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk("issue_addr_ok_wait", 32'(a_addr_ok), 32'd1);
        a_req   = 1'b1;
        a_wr    = w;
        a_addr  = a;
        a_wdata = d;
        a_wstrb = s;
        a_size  = 2'd2;
        model_req(w, a, d, s);
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0;
    endtask

    // Wait for data_ok on DUT A. start_k is the number of cycles already
    // elapsed since acceptance. The task checks the delay and the data.
    task automatic wait_resp(input int start_k, input string tag);
        int          k;
        logic [31:0] exp;
        k = start_k;
        while (a_data_ok !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(a_data_ok), 32'd1);
`ifdef DATA_SRAM_RAND_DELAY_EN
        chk({tag, "_lat_range"}, 32'(k >= LAT_A && k <= LAT_A + 3), 32'd1);
`else
        chk({tag, "_lat"}, 32'(k), 32'(LAT_A));
`endif
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        chk({tag, "_rdata"}, a_rdata, exp);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
        issue(w, a, d, s);
        wait_resp(1, tag);
    endtask

    logic [31:0] b_addr_t [8];
    logic [31:0] b_data_t [8];
    logic [31:0] b_exp_t  [8];

    initial begin
        checks  = 0;
        errors  = 0;
        resetn  = 1'b0;
        a_req = 1'b0; a_wr = 1'b0; a_size = 2'd0; a_wstrb = 4'h0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_wr = 1'b0; b_size = 2'd0; b_wstrb = 4'h0; b_addr = '0; b_wdata = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_data_ok", 32'(a_data_ok), 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        chk("rst_b_data_ok", 32'(b_data_ok), 32'd0);
        resetn = 1'b1;
        #1;
        chk("rst_a_addr_ok", 32'(a_addr_ok), 32'd1);
        chk("rst_b_addr_ok", 32'(b_addr_ok), 32'd1);
        @(negedge clk);

        // Full write, then a back-to-back read of the same word.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr_full");
        txn(1'b0, 32'h10, 32'h0, 4'h0, "rd_full");
        @(negedge clk);
        chk("single_pulse", 32'(a_data_ok), 32'd0);

        // Partial lane write.
        txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, "wr_lane1");
        issue(1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp(1, "rd_lane1");
        chk("lane_merge_const", ref_mem[word_of(32'h10)], 32'hDEADAAEF);

        // Address wrap.
        txn(1'b1, 32'h1004, 32'h12345678, 4'hF, "wr_wrap");
        txn(1'b0, 32'h0004, 32'h0, 4'h0, "rd_wrap");

        // Zero strobe still completes and leaves memory unchanged.
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, "wr_nostrb");
        txn(1'b0, 32'h10, 32'h0, 4'h0, "rd_nostrb");

        // Request presented while addr_ok=0 is ignored.
        issue(1'b0, 32'h4, 32'h0, 4'h0);
        a_req = 1'b1; a_wr = 1'b1; a_addr = 32'h10; a_wdata = 32'h0BAD0BAD; a_wstrb = 4'hF;
        chk("busy_addr_ok", 32'(a_addr_ok), 32'd0);
        @(posedge clk);
        @(negedge clk);
        a_req = 1'b0;
        wait_resp(2, "rd_busy");
        @(negedge clk);
        chk("busy_no_extra", 32'(a_data_ok), 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, "rd_after_busy");

        // Reset during WAIT after a write: no response, write stays committed.
        issue(1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        void'(exp_q.pop_back());
        resetn = 1'b0;
        #1;
        chk("mid_rst_wr_data_ok", 32'(a_data_ok), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        // Reset during WAIT after a read.
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        void'(exp_q.pop_back());
        resetn = 1'b0;
        #1;
        chk("mid_rst_rd_data_ok", 32'(a_data_ok), 32'd0);
        chk("mid_rst_rd_rdata", a_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_no_data_ok", 32'(a_data_ok), 32'd0);
            chk("post_rst_addr_ok", 32'(a_addr_ok), 32'd1);
            @(negedge clk);
        end
        txn(1'b0, 32'h20, 32'h0, 4'h0, "rd_committed");

`ifndef DATA_SRAM_RAND_DELAY_EN
        // LATENCY=1 stream with req held high: 4 writes then 4 reads.
        for (int i = 0; i < 4; i++) begin
            b_addr_t[i]   = 32'h100 + 32'(4 * i);
            b_data_t[i]   = 32'h11111111 * 32'(i + 1);
            b_exp_t[i]    = 32'd0;
        end
        b_addr_t[4] = 32'h10C; b_exp_t[4] = b_data_t[3];
        b_addr_t[5] = 32'h100; b_exp_t[5] = b_data_t[0];
        b_addr_t[6] = 32'h104; b_exp_t[6] = b_data_t[1];
        b_addr_t[7] = 32'h108; b_exp_t[7] = b_data_t[2];
        for (int i = 0; i < 8; i++) begin
            b_req   = 1'b1;
            b_wr    = (i < 4);
            b_addr  = b_addr_t[i];
            b_wdata = (i < 4) ? b_data_t[i] : 32'h0;
            b_wstrb = 4'hF;
            b_size  = 2'd2;
            @(posedge clk);
            @(negedge clk);
            chk("b2b_addr_ok", 32'(b_addr_ok), 32'd1);
            chk("b2b_data_ok", 32'(b_data_ok), 32'd1);
            chk("b2b_rdata", b_rdata, b_exp_t[i]);
        end
        b_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_drain", 32'(b_data_ok), 32'd0);
`endif

        // Random traffic on a 16-word window, with random upper and low address bits.
        for (int j = 0; j < 16; j++) begin
            txn(1'b1, 32'h200 + 32'(4 * j), $urandom, 4'hF, "rand_init");
        end
        for (int n = 0; n < N_RAND; n++) begin
            logic        w;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            a = 32'h200 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3) << 12)
                + 32'($urandom_range(0, 3));
            txn(w, a, $urandom, 4'($urandom_range(0, 15)), "rand");
            for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter ADDR_W, default 10: word-index width; the memory holds 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: number of cycles from request acceptance to data_ok.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  initiator (MEM stage) request valid.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 size  input  2  0 = byte, 1 = half, 2 = word; informational only, lanes are set by wstrb.
REQ-008 wstrb  input  4  byte-lane write enables; ignored on reads.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  write data.
REQ-011 addr_ok  output  1  responder can accept a request this cycle.
REQ-012 data_ok  output  1  one-cycle pulse that completes the oldest accepted request.
REQ-013 rdata  output  32  read data; valid only while data_ok=1 for a read.

Function
REQ-014 Acceptance shall occur on a rising edge where req=1 and addr_ok=1; at most one request shall be outstanding.
REQ-015 FSM states: IDLE, WAIT, RESP; addr_ok shall be 1 in IDLE and RESP and 0 in WAIT.
REQ-016 Word index shall be addr[ADDR_W+1:2]; all other address bits shall be ignored, so addresses wrap with no error.
REQ-017 Memory access shall happen at the acceptance edge: a write updates only the lanes selected by wstrb, and a read captures the full word into an internal result register.
REQ-018 A write with wstrb=0 shall change no memory and shall still produce data_ok.
REQ-019 A request accepted at edge T shall assert data_ok for exactly the cycle following edge T+LATENCY-1 (LATENCY=1 gives data_ok in the cycle right after acceptance).
REQ-020 Transitions: on acceptance, if the total delay is 1 go to RESP, else load the down-counter with delay-2 and go to WAIT; WAIT goes to RESP when the counter reaches 0; RESP goes to WAIT/RESP on a new acceptance, else to IDLE.
REQ-021 data_ok shall equal (state==RESP).
REQ-022 rdata shall be the captured word during data_ok for a read and 0 for a write.
REQ-023 Back-to-back traffic: a request accepted in the RESP cycle shall be served while data_ok completes the previous request, giving one completion per cycle at LATENCY=1.
REQ-024 Read-after-write to the same word accepted on consecutive edges shall return the written data.
REQ-025 Changes to req/addr/wdata while addr_ok=0 shall have no effect.

Reset
REQ-026 When resetn=0, the following shall hold immediately (asynchronously): state=IDLE, counter=0, data_ok=0, rdata=0, addr_ok=1 once resetn=1.
REQ-027 Reset mid-transaction shall discard the pending response with no data_ok; any write accepted before reset shall remain committed.
REQ-028 Memory contents shall not be reset.

Configuration
REQ-029 Macro DATA_SRAM_RAND_DELAY_EN.
REQ-030 When the macro is defined: a 16-bit LFSR (seed 16'hACE1 at reset, stepping each cycle) shall add LFSR[1:0] (range 0..3) extra cycles to each request's delay, sampled at acceptance.
REQ-031 When the macro is undefined: no LFSR logic shall exist and the delay shall be exactly LATENCY.

Verification (LATENCY=2, macro undefined unless stated)
REQ-032 Write addr=0x10, wdata=0xDEADBEEF, wstrb=4'hF at edge T; then read 0x10 -> data_ok in cycle T+2; the read's data_ok follows 2 cycles after its own acceptance with rdata=0xDEADBEEF.
REQ-033 Word 0x10 holds 0xDEADBEEF; write wstrb=4'b0010, wdata=0x0000AA00; read -> rdata=0xDEADAAEF.
REQ-034 ADDR_W=10: write addr=0x1004, then read addr=0x0004 -> same word returned (wrap).
REQ-035 LATENCY=1, req held high across 4 consecutive reads -> addr_ok constantly 1 and data_ok on 4 consecutive cycles, in order.
REQ-036 Drop resetn during WAIT after a read is accepted -> data_ok stays 0, rdata=0, addr_ok=1 after release.
REQ-037 Macro defined, 200 random requests -> every delay lies in 2..5 cycles and a scoreboard matches all data.
